// File: rtl/npu_mc_pkg.sv
// rtl/npu_mc_pkg.sv - shared request type, FSM states and widths for the memory-controller responder
package npu_mc_pkg;

  localparam int MEM_ADDR_w       = 32;
  localparam int MEM_DATA_BLOCK_w = 512;
  localparam int MASK_w           = MEM_DATA_BLOCK_w / 8;
  localparam int BLOCK_OFFSET     = 6;

  typedef struct packed {
    logic [MEM_ADDR_w-1:0]       address;
    logic [MASK_w-1:0]           dirty_mask;
    logic [MEM_DATA_BLOCK_w-1:0] data;
    logic                        is_write;
  } mc_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mc_resp_state_t;

endpackage

// File: rtl/npu_mc_responder_if.sv
// rtl/npu_mc_responder_if.sv - request/response bus between the memory tile and the responder
interface npu_mc_responder_if;
  import npu_mc_pkg::*;

  logic [MEM_ADDR_w-1:0]       n2m_request_address_i;
  logic [MASK_w-1:0]           n2m_request_dirty_mask_i;
  logic [MEM_DATA_BLOCK_w-1:0] n2m_request_data_i;
  logic                        n2m_request_read_i;
  logic                        n2m_request_write_i;
  logic                        n2m_avail_i;
  logic                        m2n_request_read_available_o;
  logic                        m2n_request_write_available_o;
  logic                        m2n_response_valid_o;
  logic [MEM_ADDR_w-1:0]       m2n_response_address_o;
  logic [MEM_DATA_BLOCK_w-1:0] m2n_response_data_o;

  modport master (
    output n2m_request_address_i, n2m_request_dirty_mask_i, n2m_request_data_i,
    output n2m_request_read_i, n2m_request_write_i, n2m_avail_i,
    input  m2n_request_read_available_o, m2n_request_write_available_o,
    input  m2n_response_valid_o, m2n_response_address_o, m2n_response_data_o
  );

  modport slave (
    input  n2m_request_address_i, n2m_request_dirty_mask_i, n2m_request_data_i,
    input  n2m_request_read_i, n2m_request_write_i, n2m_avail_i,
    output m2n_request_read_available_o, m2n_request_write_available_o,
    output m2n_response_valid_o, m2n_response_address_o, m2n_response_data_o
  );

endinterface

// File: rtl/npu_mc_req_fifo.sv
// rtl/npu_mc_req_fifo.sv - synchronous request queue of mc_req_t entries
module npu_mc_req_fifo
  import npu_mc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  mc_req_t push_req,
  input  logic    pop,
  output mc_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  mc_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/npu_mc_responder.sv
// rtl/npu_mc_responder.sv - queued block-memory responder; NPU_MC_RESP_BYTE_MASK_EN enables byte-masked writes
module npu_mc_responder
  import npu_mc_pkg::*;
#(
  parameter int MEM_BLOCKS = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 4
) (
  input  logic               clk,
  input  logic               reset,
  npu_mc_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  mc_resp_state_t              state, state_nxt;
  mc_req_t                     push_req, head, cur_req;
  logic                        fifo_full, fifo_empty, push, pop, access_last;
  logic [CNT_W-1:0]            lat_cnt;
  logic [IDX_W-1:0]            cur_idx;
  logic [MEM_DATA_BLOCK_w-1:0] mem [MEM_BLOCKS];
  logic [MEM_ADDR_w-1:0]       resp_addr;
  logic [MEM_DATA_BLOCK_w-1:0] resp_data;
  logic                        unused_req_bits;

  assign bus.m2n_request_read_available_o  = !fifo_full;
  assign bus.m2n_request_write_available_o = !fifo_full;
  assign bus.m2n_response_valid_o          = (state == RESP);
  assign bus.m2n_response_address_o        = resp_addr;
  assign bus.m2n_response_data_o           = resp_data;

  // A simultaneous read and write strobe enqueues only the write.
  assign push     = !fifo_full && (bus.n2m_request_write_i || bus.n2m_request_read_i);
  assign push_req = '{address:    bus.n2m_request_address_i,
                      dirty_mask: bus.n2m_request_dirty_mask_i,
                      data:       bus.n2m_request_data_i,
                      is_write:   bus.n2m_request_write_i};

  npu_mc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cur_idx     = cur_req.address[BLOCK_OFFSET +: IDX_W];
  assign access_last = (state == ACCESS) && (lat_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (access_last) state_nxt = cur_req.is_write ? IDLE : RESP;
      end
      RESP: begin
        if (bus.n2m_avail_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_req   <= '0;
      lat_cnt   <= '0;
      resp_addr <= '0;
      resp_data <= '0;
    end else begin
      if (pop) begin
        cur_req <= head;
        lat_cnt <= '0;
      end else if (state == ACCESS) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (access_last && !cur_req.is_write) begin
        resp_addr <= {cur_req.address[MEM_ADDR_w-1:BLOCK_OFFSET], BLOCK_OFFSET'(0)};
        resp_data <= mem[cur_idx];
      end
    end
  end

  // The array has no reset: contents stay undefined until first written.
  always_ff @(posedge clk) begin
    if (access_last && cur_req.is_write) begin
`ifdef NPU_MC_RESP_BYTE_MASK_EN
      for (int i = 0; i < MASK_w; i++) begin
        if (cur_req.dirty_mask[i]) mem[cur_idx][8*i +: 8] <= cur_req.data[8*i +: 8];
      end
`else
      mem[cur_idx] <= cur_req.data;
`endif
    end
  end

`ifdef NPU_MC_RESP_BYTE_MASK_EN
  assign unused_req_bits = ^cur_req.address[BLOCK_OFFSET-1:0];
`else
  assign unused_req_bits = ^{cur_req.address[BLOCK_OFFSET-1:0], cur_req.dirty_mask};
`endif

endmodule

// File: doc/npu_mc_responder.md
# npu_mc_responder

Memory-side responder for the NoC memory-controller interface: accepts block read/write requests issued by the memory tile, queues them, services them against an internal block-organised memory with fixed access latency, and returns read responses with a valid/avail handshake. It sits outside the NoC top level and closes the loop for system simulation and FPGA bring-up in place of an external DDR controller.

## Interface
- MEM_ADDR_w, 32: byte address width
- MEM_DATA_BLOCK_w, 512: block width in bits (64 bytes)
- MEM_BLOCKS, 1024: blocks in internal memory, power of two
- FIFO_DEPTH, 4: request queue entries, power of two, ≥2
- LATENCY, 4: access cycles per request, ≥1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- n2m_request_address_i  in  MEM_ADDR_w  request byte address
- n2m_request_dirty_mask_i  in  64  byte-enable mask for writes (bit i ↔ byte i)
- n2m_request_data_i  in  MEM_DATA_BLOCK_w  write block
- n2m_request_read_i  in  1  read request strobe
- n2m_request_write_i  in  1  write request strobe
- n2m_avail_i  in  1  requester ready to take a response
- m2n_request_read_available_o  out  1  read request can be accepted
- m2n_request_write_available_o  out  1  write request can be accepted
- m2n_response_valid_o  out  1  response valid
- m2n_response_address_o  out  MEM_ADDR_w  address of returned block
- m2n_response_data_o  out  MEM_DATA_BLOCK_w  returned block

## Operation
- Both available outputs = !fifo_full, combinational from registered count.
- Accept: read (write) strobe high while corresponding available high → enqueue {addr, mask, data, is_write}. Read and write both high: write enqueued, read dropped (protocol error).
- Block index = address[6 +: log2(MEM_BLOCKS)]; upper bits ignored (wrap-around); low 6 bits ignored, response address returned with low 6 bits zeroed.
- FSM: IDLE → ACCESS on FIFO non-empty (pop head). ACCESS counts LATENCY cycles; in its last cycle a write commits to the array, a read captures the block. After ACCESS: write → IDLE, read → RESP. RESP holds valid/address/data stable until n2m_avail_i high; transfer that cycle, → IDLE.
- Requests served strictly in FIFO order; a read after a write to the same block returns written data.
- Enqueue and pop in same cycle at full: allowed only if available was high (i.e., not full); count unchanged.
- Memory array is not cleared by reset; contents undefined until written.

## Timing
- Reset: all outputs 0 except both available = 1; FIFO empty; FSM IDLE.
- Request accepted cycle T into empty idle block: IDLE pops T+1, ACCESS T+2..T+1+LATENCY, m2n_response_valid_o high from T+2+LATENCY.
- Write committed at end of T+1+LATENCY; next request starts one cycle later.
- Back-to-back throughput: one request per LATENCY+1 cycles (writes), LATENCY+2 with n2m_avail_i high (reads).
- Reset asserted mid-operation: FIFO flushed, in-flight read response dropped, valid deasserts immediately (asynchronous); a write not yet committed is lost.

## Configuration
- NPU_MC_RESP_BYTE_MASK_EN defined: writes update only bytes whose dirty-mask bit is 1.
- Undefined: mask ignored, whole block written; n2m_request_dirty_mask_i unused.

## Structure
- Shared package npu_mc_pkg: mc_req_t struct (address, dirty_mask, data, is_write), mc_resp_state_t enum (IDLE, ACCESS, RESP), block-offset constant (6).
- Sub-module npu_mc_req_fifo: synchronous FIFO of mc_req_t, FIFO_DEPTH entries, full/empty/push/pop, asynchronous reset.

## Test plan
- Write 0x0000_0040 with data pattern A, full mask; then read 0x0000_0040 → valid at T+2+LATENCY of read accept, address 0x40, data A.
- Write pattern A, then write pattern B mask 0x0000_0000_0000_000F, read back → bytes 0–3 from B, rest A (macro defined); all B (macro undefined).
- Read with n2m_avail_i low 5 cycles → valid, address, data held stable 5 cycles, transfer on 6th, valid low next cycle.
- Issue 6 reads back-to-back with n2m_avail_i low, FIFO_DEPTH 4 → available drops after 5th accept (4 queued + 1 in service), responses return in issue order.
- Write address 0x0001_0040 with MEM_BLOCKS 1024, read 0x0000_0040 → same block data returned (wrap).
- Assert reset during RESP → valid 0 same cycle, available 1, FIFO empty, subsequent read serviced normally.
